// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker issue path: flush control/status and issue FSM states.
package mpt_pkg;

    typedef enum logic [1:0] {
        MPT_FLUSH_NONE = 2'd0,
        MPT_FLUSH_REQ  = 2'd1
    } mptw_flush_ctrl_e;

    typedef enum logic [1:0] {
        MPT_FLUSHED_NONE      = 2'd0,
        MPT_FLUSHED_ONGOING   = 2'd1,
        MPT_FLUSHED_COMPLETED = 2'd2
    } mptw_flush_status_e;

    typedef enum logic [1:0] {
        ISSUE_RUN   = 2'd0,
        ISSUE_DRAIN = 2'd1,
        ISSUE_DONE  = 2'd2
    } issue_state_e;

    // Flush status reported for each issue-stage state.
    function automatic mptw_flush_status_e issue_flush_status(issue_state_e s);
        case (s)
            ISSUE_DRAIN: return MPT_FLUSHED_ONGOING;
            ISSUE_DONE:  return MPT_FLUSHED_COMPLETED;
            default:     return MPT_FLUSHED_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mpt_sync_fifo.sv
// Synchronous FIFO with registered storage, synchronous clear and no fall-through.
// Pointers carry one extra MSB so full and empty are told apart by the wrap bit.
module mpt_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Next storage and pointer values; clear overrides any same-cycle push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_i;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/issue_queue_stage.sv
// Buffered, credit-limited MPT walker issue stage with a stop/drain/complete flush.
module issue_queue_stage
    import mpt_pkg::*;
#(
    parameter int unsigned REQ_WIDTH       = 32,
    parameter int unsigned RSP_WIDTH       = 32,
    parameter int unsigned REQ_DEPTH       = 4,
    parameter int unsigned RSP_DEPTH       = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [1:0]                                 stage_slave_valid_i,
    output logic [1:0]                                 stage_slave_ready_o,
    input  logic [REQ_WIDTH-1:0]                       stage_slave_req_data_i,
    input  logic [RSP_WIDTH-1:0]                       stage_slave_rsp_data_i,
    output logic [1:0]                                 stage_master_valid_o,
    input  logic [1:0]                                 stage_master_ready_i,
    output logic [REQ_WIDTH-1:0]                       stage_master_req_data_o,
    output logic [RSP_WIDTH-1:0]                       stage_master_rsp_data_o,
    input  logic [$bits(mptw_flush_ctrl_e)-1:0]        stage_ctrl_flush_i,
    output logic [$bits(mptw_flush_status_e)-1:0]      stage_status_flushed_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       stage_status_outstanding_o,
    output logic                                       stage_status_proto_err_o
);

    localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    issue_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;

    logic run, flush_req, flush_start;
    logic req_full, req_empty, rsp_full, rsp_empty;
    logic req_push, issue, rsp_accept, rsp_push, rsp_pop;

    assign run         = (state_q == ISSUE_RUN);
    assign flush_req   = (stage_ctrl_flush_i == MPT_FLUSH_REQ);
    assign flush_start = run && flush_req;

    // Readies and valids come only from registered state.
    assign stage_slave_ready_o[0]  = run && !req_full;
    assign stage_slave_ready_o[1]  = !run || !rsp_full;
    assign stage_master_valid_o[0] = run && !req_empty && (cnt_q < CNT_MAX);
    assign stage_master_valid_o[1] = run && !rsp_empty;

    assign req_push   = stage_slave_valid_i[0] && stage_slave_ready_o[0];
    assign issue      = stage_master_valid_o[0] && stage_master_ready_i[0];
    assign rsp_accept = stage_slave_valid_i[1] && stage_slave_ready_o[1];
    assign rsp_push   = rsp_accept && run;
    assign rsp_pop    = stage_master_valid_o[1] && stage_master_ready_i[1];

    assign stage_status_flushed_o     = issue_flush_status(state_q);
    assign stage_status_outstanding_o = cnt_q;
    assign stage_status_proto_err_o   = perr_q;

    mpt_sync_fifo #(
        .WIDTH(REQ_WIDTH),
        .DEPTH(REQ_DEPTH)
    ) u_req_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(flush_start),
        .push_i (req_push),
        .data_i (stage_slave_req_data_i),
        .pop_i  (issue),
        .data_o (stage_master_req_data_o),
        .full_o (req_full),
        .empty_o(req_empty)
    );

    mpt_sync_fifo #(
        .WIDTH(RSP_WIDTH),
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(flush_start),
        .push_i (rsp_push),
        .data_i (stage_slave_rsp_data_i),
        .pop_i  (rsp_pop),
        .data_o (stage_master_rsp_data_o),
        .full_o (rsp_full),
        .empty_o(rsp_empty)
    );

    // Outstanding count: issue adds, response removes; a response with nothing in flight is a protocol error.
    always_comb begin
        cnt_d  = cnt_q;
        perr_d = perr_q;
        if (issue && !rsp_accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp_accept && !issue) begin
            if (cnt_q == '0) begin
                perr_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Flush sequencing: stop and clear, wait for in-flight responses, hold until flush is released.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ISSUE_RUN:   if (flush_req)      state_d = ISSUE_DRAIN;
            ISSUE_DRAIN: if (cnt_q == '0)    state_d = ISSUE_DONE;
            ISSUE_DONE:  if (!flush_req)     state_d = ISSUE_RUN;
            default:                         state_d = ISSUE_RUN;
        endcase
    end

    // State, counter and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ISSUE_RUN;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: tb/tb_issue_queue_stage.sv
// Self-checking bench for issue_queue_stage: vector table, directed sequences and random traffic vs a queue model.
module tb_issue_queue_stage;
    import mpt_pkg::*;

    localparam int unsigned REQ_DEPTH = 4;
    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned MAX_OUT   = 8;
    localparam int unsigned CW        = $clog2(MAX_OUT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    sv, mr, sready, mvalid;
    logic [31:0]   req_d, rsp_d, mreq, mrsp;
    logic [1:0]    flush, status;
    logic [CW-1:0] outst;
    logic          perr;

    issue_queue_stage #(
        .REQ_WIDTH(32),
        .RSP_WIDTH(32),
        .REQ_DEPTH(REQ_DEPTH),
        .RSP_DEPTH(RSP_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .stage_slave_valid_i       (sv),
        .stage_slave_ready_o       (sready),
        .stage_slave_req_data_i    (req_d),
        .stage_slave_rsp_data_i    (rsp_d),
        .stage_master_valid_o      (mvalid),
        .stage_master_ready_i      (mr),
        .stage_master_req_data_o   (mreq),
        .stage_master_rsp_data_o   (mrsp),
        .stage_ctrl_flush_i        (flush),
        .stage_status_flushed_o    (status),
        .stage_status_outstanding_o(outst),
        .stage_status_proto_err_o  (perr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 running, 1 draining, 2 drained.
    int          m_mode;
    int          m_out;
    bit          m_perr;
    logic [31:0] m_req[$];
    logic [31:0] m_rsp[$];

    bit          acc_req, acc_rsp, did_issue, dut_iss;
    logic [31:0] dut_iss_data;

    typedef struct {
        logic [1:0]    sv;
        logic [1:0]    mr;
        logic [31:0]   rq;
        logic [31:0]   rs;
        logic          fl;
        logic [1:0]    e_sr;
        logic [1:0]    e_mv;
        logic [1:0]    e_st;
        logic [CW-1:0] e_out;
        logic          e_pe;
        logic [31:0]   e_rq;
        logic [31:0]   e_rs;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] m_ready();
        bit run = (m_mode == 0);
        bit r1  = run ? (m_rsp.size() < RSP_DEPTH) : 1'b1;
        bit r0  = run && (m_req.size() < REQ_DEPTH);
        return {r1, r0};
    endfunction

    function automatic logic [1:0] m_valid();
        bit run = (m_mode == 0);
        bit v0  = run && (m_req.size() > 0) && (m_out < MAX_OUT);
        bit v1  = run && (m_rsp.size() > 0);
        return {v1, v0};
    endfunction

    function automatic logic [1:0] m_status();
        case (m_mode)
            1:       return MPT_FLUSHED_ONGOING;
            2:       return MPT_FLUSHED_COMPLETED;
            default: return MPT_FLUSHED_NONE;
        endcase
    endfunction

    task automatic check_model();
        logic [1:0] er, ev;
        er = m_ready();
        ev = m_valid();
        chk("slave_ready", 64'(sready), 64'(er));
        chk("master_valid", 64'(mvalid), 64'(ev));
        chk("flush_status", 64'(status), 64'(m_status()));
        chk("outstanding", 64'(outst), 64'(m_out));
        chk("proto_err", 64'(perr), 64'(m_perr));
        if (ev[0]) chk("req_data", 64'(mreq), 64'(m_req[0]));
        if (ev[1]) chk("rsp_data", 64'(mrsp), 64'(m_rsp[0]));
    endtask

    // One clock: optionally compare DUT to model, then advance the model across the edge.
    task automatic tick(input bit do_chk);
        logic [1:0]  er, ev;
        logic [31:0] rq, rs;
        bit          rq_in, rs_in, iss, pop_rs, fl, r;
        int          old_out;
        er = m_ready();
        ev = m_valid();
        if (do_chk) check_model();
        r      = rst;
        fl     = (flush == MPT_FLUSH_REQ);
        rq     = req_d;
        rs     = rsp_d;
        rq_in  = sv[0] && er[0];
        iss    = ev[0] && mr[0];
        rs_in  = sv[1] && er[1];
        pop_rs = ev[1] && mr[1];
        dut_iss      = mvalid[0] && mr[0];
        dut_iss_data = mreq;
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_out = 0; m_perr = 0;
            m_req.delete(); m_rsp.delete();
            acc_req = 0; acc_rsp = 0; did_issue = 0; dut_iss = 0;
        end else begin
            acc_req   = rq_in;
            acc_rsp   = rs_in;
            did_issue = iss;
            old_out   = m_out;
            if (iss && !rs_in) m_out++;
            else if (rs_in && !iss) begin
                if (m_out == 0) m_perr = 1;
                else m_out--;
            end
            case (m_mode)
                0: begin
                    if (fl) begin
                        m_req.delete(); m_rsp.delete();
                        m_mode = 1;
                    end else begin
                        if (iss)    void'(m_req.pop_front());
                        if (pop_rs) void'(m_rsp.pop_front());
                        if (rq_in)  m_req.push_back(rq);
                        if (rs_in)  m_rsp.push_back(rs);
                    end
                end
                1: if (old_out == 0) m_mode = 2;
                default: if (!fl) m_mode = 0;
            endcase
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sv = '0; mr = '0; flush = MPT_FLUSH_NONE; req_d = '0; rsp_d = '0;
        tick(0);
        rst = 1'b0;
        chk("rst_slave_ready", 64'(sready), 64'(2'b11));
        chk("rst_master_valid", 64'(mvalid), 64'(2'b00));
        chk("rst_status", 64'(status), 64'(MPT_FLUSHED_NONE));
        chk("rst_outstanding", 64'(outst), 64'(0));
        chk("rst_proto_err", 64'(perr), 64'(0));
        chk("rst_req_data", 64'(mreq), 64'(0));
        chk("rst_rsp_data", 64'(mrsp), 64'(0));
    endtask

    initial begin
        int pushed, got, iss_cnt, bk;
        logic [CW-1:0] mx;

        //           sv     mr     rq          rs          fl  | sr    mv     st    out     pe  e_rq        e_rs
        tbl[0]  = '{2'b00, 2'b00, 32'h0,      32'h0,      0,  2'b11, 2'b00, 2'd0, CW'(0), 0, 32'h0,      32'h0};
        tbl[1]  = '{2'b01, 2'b00, 32'hA1,     32'h0,      0,  2'b11, 2'b01, 2'd0, CW'(0), 0, 32'hA1,     32'h0};
        tbl[2]  = '{2'b01, 2'b01, 32'hA2,     32'h0,      0,  2'b11, 2'b01, 2'd0, CW'(1), 0, 32'hA2,     32'h0};
        tbl[3]  = '{2'b10, 2'b01, 32'h0,      32'hB1,     0,  2'b11, 2'b10, 2'd0, CW'(1), 0, 32'h0,      32'hB1};
        tbl[4]  = '{2'b10, 2'b00, 32'h0,      32'hB2,     0,  2'b01, 2'b10, 2'd0, CW'(0), 0, 32'h0,      32'hB1};
        tbl[5]  = '{2'b00, 2'b10, 32'h0,      32'h0,      0,  2'b11, 2'b10, 2'd0, CW'(0), 0, 32'h0,      32'hB2};
        tbl[6]  = '{2'b00, 2'b10, 32'h0,      32'h0,      0,  2'b11, 2'b00, 2'd0, CW'(0), 0, 32'h0,      32'h0};
        tbl[7]  = '{2'b10, 2'b00, 32'h0,      32'hB3,     0,  2'b11, 2'b10, 2'd0, CW'(0), 1, 32'h0,      32'hB3};
        tbl[8]  = '{2'b00, 2'b00, 32'h0,      32'h0,      1,  2'b10, 2'b00, 2'd1, CW'(0), 1, 32'h0,      32'h0};
        tbl[9]  = '{2'b00, 2'b00, 32'h0,      32'h0,      1,  2'b10, 2'b00, 2'd2, CW'(0), 1, 32'h0,      32'h0};
        tbl[10] = '{2'b00, 2'b00, 32'h0,      32'h0,      1,  2'b10, 2'b00, 2'd2, CW'(0), 1, 32'h0,      32'h0};
        tbl[11] = '{2'b00, 2'b00, 32'h0,      32'h0,      0,  2'b11, 2'b00, 2'd0, CW'(0), 1, 32'h0,      32'h0};
        tbl[12] = '{2'b01, 2'b00, 32'hA3,     32'h0,      0,  2'b11, 2'b01, 2'd0, CW'(0), 1, 32'hA3,     32'h0};

        // Vector table from reset: issue, simultaneous issue/response, backpressure, spurious response, idle flush.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            sv    = tbl[i].sv;
            mr    = tbl[i].mr;
            req_d = tbl[i].rq;
            rsp_d = tbl[i].rs;
            flush = tbl[i].fl ? MPT_FLUSH_REQ : MPT_FLUSH_NONE;
            tick(1);
            chk($sformatf("vec%0d_slave_ready", i), 64'(sready), 64'(tbl[i].e_sr));
            chk($sformatf("vec%0d_master_valid", i), 64'(mvalid), 64'(tbl[i].e_mv));
            chk($sformatf("vec%0d_status", i), 64'(status), 64'(tbl[i].e_st));
            chk($sformatf("vec%0d_outstanding", i), 64'(outst), 64'(tbl[i].e_out));
            chk($sformatf("vec%0d_proto_err", i), 64'(perr), 64'(tbl[i].e_pe));
            if (tbl[i].e_mv[0]) chk($sformatf("vec%0d_req_data", i), 64'(mreq), 64'(tbl[i].e_rq));
            if (tbl[i].e_mv[1]) chk($sformatf("vec%0d_rsp_data", i), 64'(mrsp), 64'(tbl[i].e_rs));
        end

        // Back-to-back: 16 requests, backend echoes one cycle after each issue.
        do_reset();
        mr = 2'b11; sv[0] = 1'b1; req_d = 32'h100;
        pushed = 0; got = 0; mx = '0;
        for (int t = 0; t < 40 && got < 16; t++) begin
            tick(1);
            if (outst > mx) mx = outst;
            if (acc_req) begin
                pushed++;
                if (pushed < 16) req_d = 32'h100 + 32'(pushed);
                else sv[0] = 1'b0;
            end
            if (acc_rsp) sv[1] = 1'b0;
            if (dut_iss) begin
                chk("b2b_order", 64'(dut_iss_data), 64'(32'h100 + 32'(got)));
                chk("b2b_cycle", 64'(t), 64'(got + 1));
                got++;
                sv[1] = 1'b1;
                rsp_d = dut_iss_data ^ 32'hFFFF_0000;
            end
        end
        chk("b2b_count", 64'(got), 64'(16));
        chk("b2b_max_out", 64'(mx <= CW'(2)), 64'(1));

        // Credit limit with a silent backend, then one response restores one issue.
        do_reset();
        mr = 2'b01; sv[0] = 1'b1; req_d = 32'h200; iss_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (acc_req) req_d = req_d + 32'h1;
            if (dut_iss) iss_cnt++;
        end
        chk("credit_issues", 64'(iss_cnt), 64'(8));
        chk("credit_valid0", 64'(mvalid[0]), 64'(0));
        chk("credit_ready0", 64'(sready[0]), 64'(0));
        chk("credit_out", 64'(outst), 64'(8));
        sv[1] = 1'b1; rsp_d = 32'h300;
        tick(1);
        sv[1] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            if (dut_iss) iss_cnt++;
        end
        chk("credit_restore", 64'(iss_cnt), 64'(9));

        // Flush with three requests in flight.
        do_reset();
        mr = 2'b01; sv[0] = 1'b1; req_d = 32'h400; pushed = 0; iss_cnt = 0;
        for (int t = 0; t < 20 && iss_cnt < 3; t++) begin
            tick(1);
            if (acc_req) begin
                pushed++;
                if (pushed < 3) req_d = 32'h400 + 32'(pushed);
                else sv[0] = 1'b0;
            end
            if (dut_iss) iss_cnt++;
        end
        chk("f3_out", 64'(outst), 64'(3));
        mr = 2'b00; flush = MPT_FLUSH_REQ;
        tick(1);
        chk("f3_ongoing", 64'(status), 64'(MPT_FLUSHED_ONGOING));
        chk("f3_valid", 64'(mvalid), 64'(2'b00));
        chk("f3_ready", 64'(sready), 64'(2'b10));
        sv[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rsp_d = 32'h500 + 32'(k);
            tick(1);
            chk("f3_draining", 64'(status), 64'(MPT_FLUSHED_ONGOING));
        end
        sv[1] = 1'b0;
        tick(1);
        chk("f3_completed", 64'(status), 64'(MPT_FLUSHED_COMPLETED));
        chk("f3_out_zero", 64'(outst), 64'(0));
        chk("f3_no_perr", 64'(perr), 64'(0));
        flush = MPT_FLUSH_NONE;
        tick(1);
        chk("f3_none", 64'(status), 64'(MPT_FLUSHED_NONE));
        chk("f3_dropped", 64'(mvalid), 64'(2'b00));
        mr = 2'b11; sv[0] = 1'b1; req_d = 32'h4FF;
        tick(1);
        sv[0] = 1'b0;
        tick(1);
        chk("f3_resume", 64'(dut_iss), 64'(1));
        chk("f3_resume_data", 64'(dut_iss_data), 64'(32'h4FF));

        // Random traffic, flushes and occasional resets against the model.
        do_reset();
        bk = 0;
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 699) == 0);
            mr  = 2'($urandom);
            tick(1);
            if (did_issue) bk++;
            if (!sv[0] || acc_req) begin
                sv[0] = ($urandom_range(0, 3) != 0);
                req_d = $urandom;
            end
            if (!sv[1] || acc_rsp) begin
                if (acc_rsp && bk > 0) bk--;
                sv[1] = (bk > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 299) == 0);
                rsp_d = $urandom;
            end
            if (flush == MPT_FLUSH_NONE) begin
                if ($urandom_range(0, 149) == 0) flush = MPT_FLUSH_REQ;
            end else if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                flush = MPT_FLUSH_NONE;
            end
        end
        rst = 1'b0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_queue_stage.md
# issue_queue_stage

Buffered, credit-limited successor of the MPT walker issue stage. Sits between fetch and the memory backend, and between the backend and PLB lookup. It replaces the pass-through/single-register paths with parametrised request and response FIFOs, bounds in-flight backend transactions with an outstanding counter, and implements a real flush: stop, drain, then report completion.

## Interface
Parameters:
- REQ_WIDTH, 32, request payload width (fetch → backend)
- RSP_WIDTH, 32, response payload width (backend → PLB lookup)
- REQ_DEPTH, 4, request FIFO entries; power of two, ≥ 2
- RSP_DEPTH, 2, response FIFO entries; power of two, ≥ 2
- MAX_OUTSTANDING, 8, maximum requests issued to backend without a response; ≥ 1

Ports (channel 0 = request path, channel 1 = response path):
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- stage_slave_valid_i  in  2  slave valids ([0] fetch, [1] backend)
- stage_slave_ready_o  out  2  slave readies
- stage_slave_req_data_i  in  REQ_WIDTH  fetch request payload
- stage_slave_rsp_data_i  in  RSP_WIDTH  backend response payload
- stage_master_valid_o  out  2  master valids ([0] backend, [1] PLB lookup)
- stage_master_ready_i  in  2  master readies
- stage_master_req_data_o  out  REQ_WIDTH  request to backend
- stage_master_rsp_data_o  out  RSP_WIDTH  response to PLB lookup
- stage_ctrl_flush_i  in  $bits(mptw_flush_ctrl_e)  flush control
- stage_status_flushed_o  out  $bits(mptw_flush_status_e)  flush status
- stage_status_outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- stage_status_proto_err_o  out  1  sticky: response received with zero outstanding

## Operation
- Handshake on every port: transfer when valid && ready. Valid, once high, holds with stable data until accepted.
- States are RUN, DRAIN and DONE. Status output is NONE in RUN, ONGOING in DRAIN, COMPLETED in DONE.
- Request path, RUN:
  - stage_slave_ready_o[0] = !req_full.
  - stage_master_valid_o[0] = !req_empty && outstanding < MAX_OUTSTANDING.
- Outstanding counter:
  - +1 on master[0] transfer; −1 on slave[1] transfer.
  - Both in the same cycle: unchanged.
  - Decrement at 0: counter stays 0, proto_err set until reset.
- Response path, RUN:
  - stage_slave_ready_o[1] = !rsp_full.
  - stage_master_valid_o[1] = !rsp_empty.
- RUN → DRAIN when stage_ctrl_flush_i == MPT_FLUSH_REQ. On that edge both FIFOs are cleared.
- In DRAIN/DONE:
  - slave ready[0] = 0; master valids = 0.
  - slave ready[1] = 1; responses are accepted, decrement the counter and are dropped.
- DRAIN → DONE when outstanding == 0, including the first DRAIN cycle if already 0.
- DONE → RUN when stage_ctrl_flush_i != MPT_FLUSH_REQ.
- Flush has priority over any same-cycle push/pop: that cycle's handshakes still complete at the ports, but FIFO contents are discarded.

## Timing
- Reset values: state RUN, both FIFOs empty, outstanding 0, proto_err 0.
  - Outputs: valids 0, slave readies 2'b11, status MPT_FLUSHED_NONE, data outputs 0.
- FIFO latency: 1 cycle. A push at edge N is visible on the master at N+1. No fall-through.
- Throughput: 1 transfer/cycle per path. Push and pop in the same cycle are allowed when full.
- Readies depend only on registered state (full flag, FSM state), never combinationally on master ready.
- The master[0] valid gate uses the registered counter. At outstanding == MAX−1, an issue and a response in the same cycle keep issue possible next cycle.
- Flush request sampled at edge N: status ONGOING from N+1; COMPLETED no earlier than N+2.
- Reset mid-flush or mid-transfer: everything returns to reset values on the next edge. In-flight backend responses after reset raise proto_err.

## Structure
- mpt_pkg: mptw_flush_ctrl_e, mptw_flush_status_e (existing), and a new issue_state_e {ISSUE_RUN, ISSUE_DRAIN, ISSUE_DONE}.
- One sub-module: mpt_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, sync clear, full/empty.
  - Registered output; pointers are $clog2(DEPTH)+1 bits, with wrap detected by the MSB.
  - Instantiated twice.
- Top holds the FSM, the outstanding counter, proto_err, and the gating logic.

## Test plan
- Back-to-back: 16 requests with all readies high and backend echoing after 1 cycle.
  - 16 requests emerge in order, 1/cycle, 1-cycle latency.
  - outstanding never exceeds 2.
- Credit limit: MAX_OUTSTANDING=8, backend silent.
  - Exactly 8 issues, then master valid[0] = 0 and the request FIFO fills, then slave ready[0] = 0.
  - One response restores exactly one issue.
- Backpressure: master ready[1] = 0 with RSP_DEPTH=2.
  - After 2 responses, slave ready[1] = 0; data is held stable.
  - Release of ready drains both entries in order.
- Flush with 3 outstanding: assert flush.
  - Status ONGOING, FIFOs cleared.
  - 3 responses are dropped, then status COMPLETED.
  - Deasserting flush returns to NONE and traffic resumes.
- Flush with 0 outstanding: status ONGOING for exactly 1 cycle, then COMPLETED.
- Spurious response when outstanding = 0: counter stays 0 and proto_err = 1 until rst_i.
